// File: rtl/rr_req_queue_pkg.sv
// Shared sizing defaults and vector helpers for the rr_req_queue request buffer.
package rrq_pkg;

    localparam int PORT_DEF  = 4;
    localparam int W_DEF     = 8;
    localparam int DEPTH_DEF = 4;

    localparam int PTR_W = $clog2(DEPTH_DEF);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(PORT_DEF);

    // Helpers operate on a fixed-width carrier; callers zero-extend and truncate.
    localparam int VEC_MAX = 32;

    function automatic logic [VEC_MAX-1:0] lowest_bit(input logic [VEC_MAX-1:0] v);
        return v & (~v + VEC_MAX'(1));
    endfunction

    function automatic logic [VEC_MAX-1:0] onehot_to_idx(input logic [VEC_MAX-1:0] v);
        logic [VEC_MAX-1:0] idx;
        idx = '0;
        for (int i = 0; i < VEC_MAX; i++) begin
            if (v[i]) begin
                idx = idx | VEC_MAX'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_req_queue_fifo.sv
// Single synchronous FIFO used once per requester port; push is ignored when full,
// pop is ignored when empty, and head shows the oldest entry.
module rrq_fifo
    import rrq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the count unchanged.
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rr_req_queue.sv
// Per-port request buffers feeding a round-robin arbiter, with one registered output slot.
// Optional sticky grant-protocol checker enabled by defining RRQ_GRANT_CHECK_EN.
module rr_req_queue
    import rrq_pkg::*;
#(
    parameter int PORT  = PORT_DEF,
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PORT-1:0]         in_valid,
    output logic [PORT-1:0]         in_ready,
    input  logic [PORT*W-1:0]       in_data,
    output logic [PORT-1:0]         req,
    input  logic [PORT-1:0]         grant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic [$clog2(PORT)-1:0] out_port,
    output logic                    grant_err
);

    localparam int OW = $clog2(PORT);

    // Handshakes: a beat moves when valid && ready at a posedge; a valid source
    // holds its data stable until accepted; ready never depends on the same-cycle pop.
    logic [PORT-1:0] fifo_full, fifo_empty, pop;
    logic [W-1:0]    head [PORT];
    logic            slot_free, load;
    logic [PORT-1:0] eg, eg_low;
    logic [OW-1:0]   eg_idx;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [OW-1:0] out_port_q, out_port_d;

    for (genvar i = 0; i < PORT; i++) begin : g_fifo
        rrq_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (in_valid[i]),
            .push_data (in_data[i*W +: W]),
            .pop       (pop[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i]),
            .head      (head[i])
        );
    end

    assign in_ready = ~fifo_full;
    // Requests are withheld while the slot is stalled so a grant can never be dropped.
    assign slot_free = !out_valid_q || out_ready;
    assign req       = slot_free ? ~fifo_empty : '0;

    always_comb begin
        eg          = grant & req;
        eg_low      = PORT'(lowest_bit(VEC_MAX'(eg)));
        eg_idx      = OW'(onehot_to_idx(VEC_MAX'(eg_low)));
        load        = |eg;
        pop         = eg_low;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = head[eg_idx];
            out_port_d  = eg_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

`ifdef RRQ_GRANT_CHECK_EN
    logic grant_err_q, grant_err_d;

    // Flags multi-hot grants and grants to ports that were not requesting.
    always_comb begin
        grant_err_d = grant_err_q;
        if (((grant & (grant - PORT'(1))) != '0) || ((grant & ~req) != '0)) begin
            grant_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_err_q <= 1'b0;
        end else begin
            grant_err_q <= grant_err_d;
        end
    end

    assign grant_err = grant_err_q;
`else
    assign grant_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_queue.sv
// Directed bench for rr_req_queue with a behavioural round-robin arbiter and expected queue.
module tb_rr_req_queue;

    localparam int PORT = 4;
    localparam int W    = 8;
`ifdef RRQ_GRANT_CHECK_EN
    localparam logic GE_EXP = 1'b1;
`else
    localparam logic GE_EXP = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [PORT-1:0] in_valid;
    logic [PORT-1:0] in_ready;
    logic [PORT*W-1:0] in_data;
    logic [PORT-1:0] req;
    logic [PORT-1:0] grant;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [1:0]      out_port;
    logic            grant_err;

    logic            arb_mode;
    logic [PORT-1:0] grant_man;
    logic [1:0]      rr_ptr, rr_next;
    logic [PORT-1:0] rr_grant;
    logic            rr_found;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    rr_req_queue #(.PORT(PORT), .W(W), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_port  (out_port),
        .grant_err (grant_err)
    );

    // Clock and reset-driven arbiter model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        rr_next  = rr_ptr;
        for (int k = 0; k < PORT; k++) begin
            if (!rr_found && req[(int'(rr_ptr) + k) % PORT]) begin
                rr_grant[(int'(rr_ptr) + k) % PORT] = 1'b1;
                rr_next  = 2'((int'(rr_ptr) + k + 1) % PORT);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (arb_mode && rr_found) begin
            rr_ptr <= rr_next;
        end
    end

    assign grant = arb_mode ? rr_grant : grant_man;

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        arb_mode  = 1'b0;
        grant_man = '0;
        repeat (2) tick();
        reset = 1'b0;

        // Idle after reset.
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_out_port", 32'(out_port), 32'h0);
        for (int i = 0; i < 10; i++) begin
            check_eq("idle_in_ready", 32'(in_ready), 32'hF);
            check_eq("idle_req", 32'(req), 32'h0);
            check_eq("idle_out_valid", 32'(out_valid), 32'h0);
            check_eq("idle_grant_err", 32'(grant_err), 32'h0);
            tick();
        end

        // Single push on port 2, two-cycle latency.
        arb_mode = 1'b1;
        in_valid = 4'b0100;
        in_data  = 32'h00A5_0000;
        tick();
        in_valid = '0;
        check_eq("lat_req_c1", 32'(req), 32'h4);
        check_eq("lat_valid_c1", 32'(out_valid), 32'h0);
        tick();
        check_eq("lat_valid_c2", 32'(out_valid), 32'h1);
        check_eq("lat_data_c2", 32'(out_data), 32'hA5);
        check_eq("lat_port_c2", 32'(out_port), 32'h2);
        check_eq("lat_req_c2", 32'(req), 32'h0);
        tick();
        check_eq("lat_drain", 32'(out_valid), 32'h0);

        // Fill port 0, refuse a fifth push, drain in order.
        arb_mode = 1'b0;
        do_reset();
        for (int e = 0; e < 4; e++) begin
            in_valid = 4'b0001;
            in_data  = 32'(8'h10 + 8'(e));
            tick();
        end
        check_eq("full_in_ready", 32'(in_ready), 32'hE);
        check_eq("full_req", 32'(req), 32'h1);
        in_data = 32'h99;
        tick();
        in_valid = '0;
        check_eq("full_refused", 32'(in_ready), 32'hE);
        grant_man = 4'b0001;
        for (int e = 0; e < 4; e++) begin
            tick();
            check_eq("fill_valid", 32'(out_valid), 32'h1);
            check_eq("fill_data", 32'(out_data), 32'(8'h10 + 8'(e)));
            check_eq("fill_port", 32'(out_port), 32'h0);
        end
        grant_man = '0;
        tick();
        check_eq("fill_empty_valid", 32'(out_valid), 32'h0);
        check_eq("fill_empty_ready", 32'(in_ready), 32'hF);

        // All ports two deep, round-robin order, one per cycle.
        do_reset();
        for (int e = 0; e < 2; e++) begin
            in_valid = 4'b1111;
            for (int p = 0; p < PORT; p++) begin
                in_data[p*W +: W] = 8'(8'h20 + 8'(p * 16) + 8'(e));
                exp_q.push_back(8'(8'h20 + 8'(p * 16) + 8'(e)));
            end
            tick();
        end
        in_valid = '0;
        arb_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("rr_valid", 32'(out_valid), 32'h1);
            check_eq("rr_port", 32'(out_port), 32'(i % PORT));
            check_eq("rr_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        arb_mode = 1'b0;
        tick();
        check_eq("rr_done_valid", 32'(out_valid), 32'h0);
        check_eq("rr_queue_empty", 32'(exp_q.size()), 32'h0);

        // Stall: slot holds, requests withheld, stray grants ignored, then reset.
        do_reset();
        in_valid = 4'b1010;
        in_data  = 32'h7300_3100;
        tick();
        in_valid  = '0;
        out_ready = 1'b0;
        grant_man = 4'b0010;
        tick();
        grant_man = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 32'(out_valid), 32'h1);
            check_eq("stall_data", 32'(out_data), 32'h31);
            check_eq("stall_port", 32'(out_port), 32'h1);
            check_eq("stall_req", 32'(req), 32'h0);
            tick();
        end
        check_eq("stall_in_ready", 32'(in_ready), 32'hF);
        check_eq("stall_grant_err", 32'(grant_err), 32'(GE_EXP));
        grant_man = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
        check_eq("mid_rst_data", 32'(out_data), 32'h0);
        check_eq("mid_rst_port", 32'(out_port), 32'h0);
        check_eq("mid_rst_req", 32'(req), 32'h0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'hF);
        check_eq("mid_rst_grant_err", 32'(grant_err), 32'h0);

        // Multi-hot grant: lowest port wins; checker flag is sticky when built in.
        out_ready = 1'b1;
        in_valid  = 4'b0011;
        in_data   = 32'h0000_0201;
        tick();
        in_valid = '0;
        check_eq("mh_req", 32'(req), 32'h3);
        grant_man = 4'b0011;
        tick();
        grant_man = '0;
        check_eq("mh_data", 32'(out_data), 32'h01);
        check_eq("mh_port", 32'(out_port), 32'h0);
        check_eq("mh_req_after", 32'(req), 32'h2);
        check_eq("mh_grant_err", 32'(grant_err), 32'(GE_EXP));
        tick();
        check_eq("mh_idle_valid", 32'(out_valid), 32'h0);
        check_eq("mh_err_sticky", 32'(grant_err), 32'(GE_EXP));
        grant_man = 4'b0010;
        tick();
        grant_man = '0;
        check_eq("mh_second_data", 32'(out_data), 32'h02);
        check_eq("mh_second_port", 32'(out_port), 32'h1);
        do_reset();
        check_eq("mh_err_cleared", 32'(grant_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
